if_id_buffer: RTL
=================

# if_id_buffer

Parametrised fetch-to-decode instruction buffer: a DEPTH-entry FIFO of {pc, inst} pairs between the IF and ID stages. It replaces the single-entry if/id register, adding a valid/ready handshake on both sides, back-pressure to fetch, decode stall absorption and a one-cycle flush on branch redirect. Empty or flushed output presents a zero bubble (pc = 0, inst = 0) to decode.

## Interface
- ADDR_WIDTH, 32, PC width
- INST_WIDTH, 32, instruction width
- DEPTH, 4, entry count; power of two, ≥ 2
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- branch_flag_i  in  1  flush request; discards every buffered and incoming entry
- if_valid_i  in  1  fetch presents a valid pc/inst this cycle
- if_pc_i  in  ADDR_WIDTH  fetch PC
- if_inst_i  in  INST_WIDTH  fetched instruction
- if_ready_o  out  1  buffer can accept a push this cycle
- id_valid_o  out  1  head entry valid for decode
- id_ready_i  in  1  decode consumes head this cycle (0 = decode stall)
- id_pc_o  out  ADDR_WIDTH  head PC; 0 when id_valid_o = 0
- id_inst_o  out  INST_WIDTH  head instruction; 0 when id_valid_o = 0
- count_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH-entry register array, write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH; occupancy counter cnt, $clog2(DEPTH)+1 bits.
- push = if_valid_i & if_ready_o; pop = id_valid_o & id_ready_i.
- if_ready_o = (cnt != DEPTH); depends on registered cnt only, never on id_ready_i (no pass-through when full).
- id_valid_o = (cnt != 0); id_pc_o/id_inst_o = entry[rd_ptr] when valid, else forced to 0.
- Priority per cycle: rst > branch_flag_i > push/pop.
- rst: wr_ptr = rd_ptr = cnt = 0; storage contents irrelevant (outputs masked to 0).
- branch_flag_i (rst low): wr_ptr = rd_ptr = cnt = 0; push and pop in the same cycle are ignored, incoming entry dropped; decode must not treat a pop during a flush cycle as committed.
- push only: entry[wr_ptr] <= {if_pc_i, if_inst_i}; wr_ptr+1; cnt+1.
- pop only: rd_ptr+1; cnt-1.
- push and pop together: both pointers advance, cnt unchanged; legal at any cnt in 1..DEPTH-1 (push blocked at DEPTH, pop impossible at 0).
- No bypass: an entry pushed while empty is not visible on id_* in the same cycle.
- if_valid_i with if_ready_o = 0: no state change; fetch must hold pc/inst until accepted.
- id_ready_i while empty: no effect.

## Timing
- All outputs are functions of registered state only (no input-to-output combinational path); if_ready_o, id_valid_o, id_*_o, count_o all settle after posedge.
- Reset values (cycle after rst high): if_ready_o = 1, id_valid_o = 0, id_pc_o = 0, id_inst_o = 0, count_o = 0.
- Latency: push at edge N -> visible on id_* after edge N (earliest decode consume at edge N+1); minimum 1 cycle, equal to the old single register.
- Flush at edge N -> after edge N: id_valid_o = 0, outputs 0, if_ready_o = 1; fetch of redirect target may push on cycle N+1.
- Throughput: one push and one pop per cycle sustained once non-empty.
- Full: cnt = DEPTH -> if_ready_o = 0 until a pop edge; push re-enabled the cycle after that pop.
- Wrap-around: pointers roll from DEPTH-1 to 0 without gap or loss; ordering strictly FIFO.

## Test plan
- Reset: hold rst 2 cycles with if_valid_i = 1 -> count_o = 0, id_valid_o = 0, id_pc_o = id_inst_o = 0, if_ready_o = 1; no entry enqueued.
- Streaming: push pc 0x1c000000, +4, +8… with id_ready_i = 1 -> id_pc_o follows 1 cycle behind, count_o stays 1, 20 consecutive entries in order, crossing pointer wrap 5 times.
- Decode stall/full: id_ready_i = 0, push 6 entries (pc 0x100..0x114) with DEPTH = 4 -> first 4 accepted, if_ready_o = 0 from cycle after 4th push, count_o = 4, 5th held; raise id_ready_i -> 0x100..0x114 emerge in order, no duplicate or drop.
- Flush: 3 entries buffered, assert branch_flag_i with if_valid_i = 1 and id_ready_i = 1 -> next cycle count_o = 0, id_valid_o = 0, outputs 0, flush-cycle fetch entry absent; push pc 0x2000 next cycle -> appears as head following cycle.
- Simultaneous push/pop at cnt = 3 (DEPTH = 4) -> count_o remains 3, head advances one entry, if_ready_o stays 1.
- Reset mid-operation: rst with 4 entries buffered and branch_flag_i = 1 -> reset state as above; subsequent push of 0x3000 is head one cycle later.

Source files
------------

// File: rtl/if_id_buffer.sv
// Fetch-to-decode instruction buffer.
// DEPTH-entry FIFO of {pc, inst} pairs with valid/ready on both sides.
// Branch redirect flushes every buffered and incoming entry in one cycle.
// An empty or flushed buffer presents an all-zero bubble to decode.
// All outputs come from registered state only; there is no same-cycle bypass.
module if_id_buffer #(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       branch_flag_i,
   input  logic                       if_valid_i,
   input  logic [ADDR_WIDTH-1:0]      if_pc_i,
   input  logic [INST_WIDTH-1:0]      if_inst_i,
   output logic                       if_ready_o,
   output logic                       id_valid_o,
   input  logic                       id_ready_i,
   output logic [ADDR_WIDTH-1:0]      id_pc_o,
   output logic [INST_WIDTH-1:0]      id_inst_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_WIDTH-1:0] pc_mem_r   [DEPTH];
   logic [INST_WIDTH-1:0] inst_mem_r [DEPTH];

   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] cnt_r;

   logic [PTR_W-1:0] wr_ptr_nxt_s;
   logic [PTR_W-1:0] rd_ptr_nxt_s;
   logic [CNT_W-1:0] cnt_nxt_s;

   logic push_s;
   logic pop_s;
   logic mem_we_s;

   // Handshake decode: ready and valid depend only on the registered count.
   always_comb begin
      if_ready_o = (cnt_r != CNT_W'(DEPTH));
      id_valid_o = (cnt_r != {CNT_W{1'b0}});
      push_s     = if_valid_i & if_ready_o;
      pop_s      = id_valid_o & id_ready_i;
      mem_we_s   = push_s & ~rst & ~branch_flag_i;
   end

   // Next-state for pointers and occupancy: reset beats flush beats push/pop.
   always_comb begin
      wr_ptr_nxt_s = wr_ptr_r;
      rd_ptr_nxt_s = rd_ptr_r;
      cnt_nxt_s    = cnt_r;
      if (rst || branch_flag_i) begin
         wr_ptr_nxt_s = {PTR_W{1'b0}};
         rd_ptr_nxt_s = {PTR_W{1'b0}};
         cnt_nxt_s    = {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
         end else begin
            wr_ptr_nxt_s = wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
         end else begin
            rd_ptr_nxt_s = rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1);
            2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1);
            default: cnt_nxt_s = cnt_r;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      cnt_r    <= cnt_nxt_s;
   end

   // Entry storage; contents need no reset because empty output is masked.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         pc_mem_r[wr_ptr_r]   <= if_pc_i;
         inst_mem_r[wr_ptr_r] <= if_inst_i;
      end
   end

   // Head presentation: zero bubble whenever nothing valid is buffered.
   always_comb begin
      count_o = cnt_r;
      if (id_valid_o) begin
         id_pc_o   = pc_mem_r[rd_ptr_r];
         id_inst_o = inst_mem_r[rd_ptr_r];
      end else begin
         id_pc_o   = {ADDR_WIDTH{1'b0}};
         id_inst_o = {INST_WIDTH{1'b0}};
      end
   end

endmodule
